// File: rtl/lab3_pkg.sv
// lab3_pkg: shared word type, counter width and index sizing for the Lab 3 deserializer.
package lab3_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int FRAME_CNT_W = 8;
    typedef logic [DEFAULT_WIDTH-1:0] word_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lab3_word_reg.sv
// lab3_word_reg: WIDTH-bit load-enabled register, async active-low clear.
module lab3_word_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) data_q <= '0;
        else if (en_i) data_q <= d_i;
    end
    assign q_o = data_q;
endmodule

// File: rtl/lab3_word_deserializer.sv
// lab3_word_deserializer: packs N chain words into one frame on a valid/ready port.
// Only the last word of a frame can stall, and only while a held frame is unconsumed.
module lab3_word_deserializer
    import lab3_pkg::*;
#(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [N*WIDTH-1:0]     out_frame,
    input  logic                   out_ready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam int IW = idx_w(N);
    logic [IW-1:0]              idx_q, idx_d;
    logic [N*WIDTH-1:0]         frame_q, frame_d;
    logic                       valid_q, valid_d;
    logic [FRAME_CNT_W-1:0]     cnt_q, cnt_d;
    logic [(N-1)*WIDTH-1:0]     asm_w;
    logic                       last, in_xfer, out_xfer, load;
    assign last     = idx_q == IW'(N-1);
    assign in_ready = !(last && valid_q && !out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;
    assign load     = in_xfer && last;
    for (genvar g = 0; g < N-1; g++) begin : g_slot
        lab3_word_reg #(.WIDTH(WIDTH)) u_slot (
            .clock(clock),
            .reset(reset),
            .en_i (in_xfer && idx_q == IW'(g)),
            .d_i  (in_data),
            .q_o  (asm_w[g*WIDTH +: WIDTH])
        );
    end
    // A final-word load during a hand-off replaces the frame and keeps valid high.
    always_comb begin
        idx_d   = in_xfer ? (last ? '0 : idx_q + 1'b1) : idx_q;
        frame_d = load ? {in_data, asm_w} : frame_q;
        valid_d = load || (valid_q && !out_ready);
        cnt_d   = cnt_q + FRAME_CNT_W'(out_xfer);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
    assign out_valid = valid_q;
    assign out_frame = frame_q;
    assign frame_cnt = cnt_q;
endmodule

// File: doc/lab3_word_deserializer.md
# lab3_word_deserializer

Receiving end of the Lab 3 word delay chain: accepts one WIDTH-bit word per cycle from the tail of a D flip-flop register chain and packs N consecutive words into one parallel frame. The frame is presented on a valid/ready output port. The block sits between the register chain and any frame-wide consumer. It provides back-pressure to the chain through in_ready, so no word is ever dropped.

## Interface
- Parameters:
- N, 10: words per frame; legal range 2..64.
- WIDTH, 4: bits per word (matches the chain register width).
- Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a word this cycle.
- in_data  input  WIDTH  word from the chain tail.
- in_ready  output  1  the block accepts in_data this cycle.
- out_valid  output  1  out_frame holds a complete frame.
- out_frame  output  N*WIDTH  assembled frame; word k at bits [k*WIDTH +: WIDTH]; first-received word in the LSBs.
- out_ready  input  1  the consumer takes the frame this cycle.
- frame_cnt  output  8  number of frames handed off (out_valid && out_ready), modulo 256.

## Operation
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Storage is two registers:
  - assembly buffer: (N-1)*WIDTH bits.
  - output buffer: N*WIDTH bits plus out_valid.
- Word index idx: range 0..N-1, counts words accepted into the current frame.
- Input transfer with idx < N-1:
  - in_data is written to assembly slot idx.
  - idx increments.
- Input transfer with idx == N-1:
  - The output buffer loads {in_data, assembly}.
  - out_valid is set.
  - idx wraps to 0.
- in_ready = !(idx == N-1 && out_valid && !out_ready). Only the final word of a frame is ever stalled.
- On an output transfer with no simultaneous load, out_valid clears and frame_cnt increments (8'hFF wraps to 8'h00).
- Simultaneous output transfer and final-word load: the new frame replaces the old one, out_valid stays 1, and frame_cnt increments. This sustains full throughput of one frame per N cycles.
- in_valid low: idx holds and no state changes; gaps are allowed anywhere inside a frame.
- in_data is ignored whenever in_valid is low or in_ready is low.
- The assembly buffer is not cleared between frames; stale slots are always overwritten before use.

## Timing
- Reset (reset == 0, asynchronous) clears:
  - idx = 0
  - out_valid = 0
  - out_frame = 0
  - frame_cnt = 0
  - all assembly slots = 0
- Reset values of the remaining output: in_ready = 1 (combinational from idx, out_valid and out_ready).
- Reset deassertion is synchronous to clock; the first input transfer can occur on the first rising edge after release.
- Reset asserted mid-frame discards the partial frame and any held frame; it does not count as a hand-off.
- Latency: out_valid rises on the clock edge that accepts the Nth word and is visible the following cycle.
- out_frame and out_valid are registered. out_frame is stable while out_valid && !out_ready.
- in_ready is the only combinational output; it depends on out_ready, with no combinational path from in_valid.

## Structure
- Shared package lab3_pkg, holding:
  - typedef logic [WIDTH-1:0] word_t (default WIDTH 4);
  - localparam FRAME_CNT_W = 8;
  - index width computed as $clog2(N).
- Sub-module lab3_word_reg: WIDTH-bit D register with load enable and asynchronous active-low reset to 0. Instantiated once per assembly slot from a generate loop.
- Top level contains:
  - the idx counter;
  - the output buffer and out_valid flag;
  - the frame_cnt counter;
  - the in_ready logic.

## Test plan
- Reset then 10 words 0x1..0xA with in_valid=1 and out_ready=1 -> the cycle after word 10, out_valid=1 and out_frame=40'hA987654321; frame_cnt=1 the cycle after.
- Hold out_ready=0 after the first frame and stream 10 more words 0x0..0x9 -> in_ready=0 only while word 0x9 is presented; the first frame stays stable until out_ready=1, then 40'h9876543210 loads in the same cycle and frame_cnt increments.
- Random in_valid gaps (~50%) over 20 words -> frames match a reference queue model word for word.
- Assert reset after 5 words of a frame, release, then send 10 words 0xF -> a single frame 40'hFFFFFFFFFF; no leftover words from before reset.
- Continuous streaming of 256 frames with out_ready=1 -> frame_cnt wraps to 0 and one frame is delivered every 10 cycles.
- N=2, WIDTH=8, words 0x12 then 0x34 -> out_frame=16'h3412.
